// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage between execute and writeback. It takes one
// instruction at a time from the EX-to-MEM bus under a valid/allowin
// handshake. Loads and stores go out over a single-outstanding request/
// response data-memory port. Load data is lane-selected and sign- or
// zero-extended before it is handed to writeback.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   ex_to_mem_valid     upstream holds a valid instruction
//   ex_to_mem_bus       {pc, reg_wen, rd, alu_result, mem_ren, mem_wen,
//                        mem_size, load_unsigned, store_data}
//   mem_allowin         stage can accept an instruction this cycle
//   mem_to_wb_valid     mem_to_wb_bus holds a finished instruction
//   mem_to_wb_bus       {pc, reg_wen, rd, wdata}
//   wb_allowin          writeback accepts this cycle
//   dmem_req_*          request channel: valid/ready, store flag, 8-byte
//                        aligned address, lane-shifted write data and mask
//   dmem_resp_*         one-cycle response pulse with aligned read data
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int EX_TO_MEM_WIDTH = 171,
    parameter int MEM_TO_WB_WIDTH = 102
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_to_mem_valid,
    input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
    output logic                       mem_allowin,
    output logic                       mem_to_wb_valid,
    output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
    input  logic                       wb_allowin,
    output logic                       dmem_req_valid,
    input  logic                       dmem_req_ready,
    output logic                       dmem_req_wen,
    output logic [63:0]                dmem_req_addr,
    output logic [63:0]                dmem_req_wdata,
    output logic [7:0]                 dmem_req_wmask,
    input  logic                       dmem_resp_valid,
    input  logic [63:0]                dmem_resp_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Formatting helpers
    // -------------------------------------------------------------------------

    // Byte offset inside the 8-byte word, with the bits below the access size
    // forced to zero so that an access never straddles its natural alignment.
    function automatic logic [2:0] lane_offset(input logic [2:0] addr_low,
                                               input logic [1:0] size);
        logic [2:0] off;
        case (size)
            2'd0:    off = addr_low;
            2'd1:    off = {addr_low[2:1], 1'b0};
            2'd2:    off = {addr_low[2], 2'b00};
            default: off = 3'b000;
        endcase
        return off;
    endfunction

    // Byte-lane write mask: (2^(2^size) - 1) << offset. The offset is already
    // aligned to the size, so the shifted mask always fits in eight lanes.
    function automatic logic [7:0] store_mask(input logic [1:0] size,
                                              input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] store_lanes(input logic [63:0] data,
                                                input logic [2:0]  off);
        return data << {off, 3'b000};
    endfunction

    // Pull the addressed lanes down to bit 0, truncate to the access size and
    // extend back to 64 bits. Dword accesses pass straight through.
    function automatic logic [63:0] format_load(input logic [63:0] rdata,
                                                input logic [1:0]  size,
                                                input logic [2:0]  off,
                                                input logic        is_unsigned);
        logic        [63:0] raw;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] w_s;
        logic        [63:0] res;
        raw = rdata >> {off, 3'b000};
        b_s = signed'(raw[7:0]);
        h_s = signed'(raw[15:0]);
        w_s = signed'(raw[31:0]);
        case (size)
            2'd0:    res = is_unsigned ? {56'd0, raw[7:0]}  : 64'(b_s);
            2'd1:    res = is_unsigned ? {48'd0, raw[15:0]} : 64'(h_s);
            2'd2:    res = is_unsigned ? {32'd0, raw[31:0]} : 64'(w_s);
            default: res = raw;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Stage registers
    // -------------------------------------------------------------------------
    logic                       mem_valid;
    logic [EX_TO_MEM_WIDTH-1:0] mem_bus_p0;
    state_t                     state;
    state_t                     state_next;
    logic [63:0]                load_buf;

    logic                       ready_go;
    logic                       req_valid;
    logic                       capture;

    // Fields of the latched instruction
    logic [31:0] pc;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] alu_result;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [63:0] store_data;
    logic        mem_op;
    logic [2:0]  offset;
    logic [63:0] wdata;

    // Incoming instruction is a memory op (used for the DONE -> REQ shortcut)
    logic        next_is_mem_op;

    assign pc            = mem_bus_p0[170:139];
    assign reg_wen       = mem_bus_p0[138];
    assign rd            = mem_bus_p0[137:133];
    assign alu_result    = mem_bus_p0[132:69];
    assign mem_ren       = mem_bus_p0[68];
    assign mem_wen       = mem_bus_p0[67];
    assign mem_size      = mem_bus_p0[66:65];
    assign load_unsigned = mem_bus_p0[64];
    assign store_data    = mem_bus_p0[63:0];

    assign mem_op         = mem_ren | mem_wen;
    assign offset         = lane_offset(alu_result[2:0], mem_size);
    assign next_is_mem_op = ex_to_mem_valid & (ex_to_mem_bus[68] | ex_to_mem_bus[67]);

    // -------------------------------------------------------------------------
    // Access FSM: next state and request/handshake controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        capture    = 1'b0;
        ready_go   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_valid && mem_op) begin
                    // Request goes out in the same cycle the op is latched
                    req_valid  = 1'b1;
                    state_next = dmem_req_ready ? ST_WAIT : ST_REQ;
                end else begin
                    ready_go = 1'b1;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_resp_valid) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_go = 1'b1;
                if (wb_allowin) begin
                    // Transfer happens now; a memory op accepted on the same
                    // edge starts requesting straight away.
                    state_next = next_is_mem_op ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_allowin     = !mem_valid || (ready_go && wb_allowin);
    assign mem_to_wb_valid = mem_valid && ready_go;

    // -------------------------------------------------------------------------
    // Stage boundary: control state (reset) and payload latch (not reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            state     <= ST_IDLE;
            load_buf  <= 64'd0;
        end else begin
            state <= state_next;
            if (mem_allowin) begin
                mem_valid <= ex_to_mem_valid;
            end
            if (capture) begin
                load_buf <= format_load(dmem_resp_rdata, mem_size, offset, load_unsigned);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_allowin) begin
            mem_bus_p0 <= ex_to_mem_bus;
        end
    end

    // -------------------------------------------------------------------------
    // Memory request and writeback payload
    // -------------------------------------------------------------------------
    assign dmem_req_valid = req_valid;
    assign dmem_req_wen   = req_valid && mem_wen;
    assign dmem_req_addr  = {alu_result[63:3], 3'b000};
    assign dmem_req_wdata = store_lanes(store_data, offset);
    assign dmem_req_wmask = (req_valid && mem_wen) ? store_mask(mem_size, offset) : 8'h00;

    assign wdata         = mem_ren ? load_buf : alu_result;
    assign mem_to_wb_bus = {pc, reg_wen, rd, wdata};

endmodule
